// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
//
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CHK) over a
// valid/ready handshake, assembles little-endian 32-bit words and writes them
// to consecutive word addresses starting at BASE_ADDR. The core is held in
// reset until the frame's XOR checksum verifies.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   in_valid     - byte-stream valid
//   in_data      - byte-stream data
//   in_ready     - loader can accept a byte (decoded from state)
//   restart      - reload request, honoured only in S_DONE / S_ERR
//   imem_we      - one-cycle write pulse per assembled word
//   imem_addr    - registered word address (holds when imem_we=0)
//   imem_wdata   - registered write data (holds when imem_we=0)
//   core_rst_n   - active-low core reset, high only in S_DONE
//   done         - frame loaded and checksum matched
//   error        - frame rejected (oversize or bad checksum)
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count; 17 bits so ADDR_WIDTH up to 16 still fits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            xor_q, xor_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           asm_q, asm_d;     // lower three bytes of the word in progress
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           len_full;

    assign in_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
    assign accept     = in_valid && in_ready;
    assign len_full   = {in_data, len_q[7:0]};

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign core_rst_n = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LEN0;
            lane_q  <= 2'd0;
            cnt_q   <= 16'd0;
            xor_q   <= 8'd0;
            len_q   <= 16'd0;
            asm_q   <= 24'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        len_d   = len_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    xor_d      = xor_q ^ in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    xor_d = xor_q ^ in_data;
                    if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ in_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            // Final byte completes the word; the write shows up next cycle.
                            we_d    = 1'b1;
                            addr_d  = ADDR_WIDTH'(BASE_ADDR + 32'(cnt_q));
                            wdata_d = {in_data, asm_q};
                            cnt_d   = cnt_q + 16'd1;
                            if (cnt_q == len_q - 16'd1) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_LEN0;
                    lane_d  = 2'd0;
                    cnt_d   = 16'd0;
                    xor_d   = 8'd0;
                    len_d   = 16'd0;
                    asm_d   = 24'd0;
                end
            end
            default: state_d = S_LEN0;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned BASE = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          restart = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          error;

    imem_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .restart   (restart),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            got_cyc[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
            got_cyc.push_back(cyc);
        end
    end

    // Frame under test and model expectations
    logic [7:0]    frame_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    bit            exp_done;
    bit            exp_err;
    int            exp_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    // Frame-level model: what the frame means, not how the loader walks it.
    task automatic model();
        int          n;
        logic [7:0]  x;
        exp_addr.delete();
        exp_data.delete();
        n = {frame_q[1], frame_q[0]};
        if (n > (1 << AW)) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_len  = 2;
        end else begin
            x = 8'd0;
            for (int i = 0; i < 2 + 4 * n; i++) x ^= frame_q[i];
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(AW'((BASE + w) % (1 << AW)));
                exp_data.push_back({frame_q[2+4*w+3], frame_q[2+4*w+2],
                                    frame_q[2+4*w+1], frame_q[2+4*w]});
            end
            exp_len  = 3 + 4 * n;
            exp_done = (frame_q[2+4*n] == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic make_frame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x ^= b;
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    // Entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_wait", 64'(ok), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({tag, " rs_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " rs_done"}, 64'(done), 64'd0);
        chk({tag, " rs_error"}, 64'(error), 64'd0);
        chk({tag, " rs_core_rst_n"}, 64'(core_rst_n), 64'd0);
    endtask

    task automatic run_frame(input string tag, input int max_gap);
        int m;
        model();
        clear_got();
        for (int i = 0; i < exp_len; i++) begin
            if (i == 2) begin
                // Restart mid-frame must be ignored.
                in_valid = 1'b0;
                restart  = 1'b1;
                @(negedge clk);
                restart  = 1'b0;
            end
            send_byte(frame_q[i], $urandom_range(0, max_gap));
        end
        repeat (3) @(negedge clk);
        chk({tag, " nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
            chk($sformatf("%s data[%0d]", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
        end
        chk({tag, " done"}, 64'(done), 64'(exp_done));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " we"}, 64'(imem_we), 64'd0);
        chk({tag, " addr"}, 64'(imem_addr), 64'd0);
        chk({tag, " wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " core_rst_n"}, 64'(core_rst_n), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int bad_gap;

        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single word with exact write timing
        clear_got();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        chk("single we_before", 64'(imem_we), 64'd0);
        send_byte(8'hDE, 0);
        chk("single we_pulse", 64'(imem_we), 64'd1);
        chk("single addr", 64'(imem_addr), 64'h00);
        chk("single wdata", 64'(imem_wdata), 64'hDEADBEEF);
        send_byte(8'h23, 0);
        chk("single we_after", 64'(imem_we), 64'd0);
        chk("single wdata_hold", 64'(imem_wdata), 64'hDEADBEEF);
        repeat (2) @(negedge clk);
        chk("single nwrites", 64'(got_addr.size()), 64'd1);
        chk("single done", 64'(done), 64'd1);
        chk("single core_rst_n", 64'(core_rst_n), 64'd1);
        chk("single in_ready", 64'(in_ready), 64'd0);
        chk("single error", 64'(error), 64'd0);
        do_restart("single");

        // Empty program
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", 0);
        do_restart("empty");

        // Bad checksum
        frame_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF};
        run_frame("badchk", 0);
        chk("badchk wdata", 64'(imem_wdata), 64'h12345678);
        do_restart("badchk");

        // Oversize length
        frame_q = '{8'h01, 8'h01};
        run_frame("oversize", 0);
        do_restart("oversize");

        // Stalled 2-word stream
        make_frame(2, 1'b0);
        run_frame("stall", 5);
        do_restart("stall");

        // Reset in the middle of a word
        clear_got();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk("midrst nwrites", 64'(got_addr.size()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        make_frame(1, 1'b0);
        run_frame("post_rst", 2);
        do_restart("post_rst");

        // Full-size program at maximum rate: one write every 4 cycles
        make_frame(1 << AW, 1'b0);
        run_frame("full", 0);
        bad_gap = 0;
        for (int i = 1; i < got_cyc.size(); i++) begin
            if (got_cyc[i] - got_cyc[i-1] != 4) bad_gap++;
        end
        chk("full write_spacing", 64'(bad_gap), 64'd0);
        do_restart("full");

        // Randomized frames, some with corrupted checksum
        for (int f = 0; f < 8; f++) begin
            make_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            run_frame($sformatf("rand%0d", f), 3);
            do_restart($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
